// File: rtl/ysyx_23060077_icache_axi_rd_if.sv
// AXI4 read-only channel bundle (AR + R) between the icache refill master and memory.
// master: drives AR request and rready; slave: drives arready and the R payload.
interface ysyx_23060077_icache_axi_rd_if #(
    parameter int unsigned ID_WIDTH = 4
);
    logic                arvalid;
    logic                arready;
    logic [31:0]         araddr;
    logic [ID_WIDTH-1:0] arid;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;

    logic                rvalid;
    logic                rready;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic [ID_WIDTH-1:0] rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_23060077_icache_axi_rd.sv
// Icache line-refill AXI4 read-burst master.
// One refill request (valid/addr/len) becomes one INCR AR burst; each R beat is
// forwarded to the cache in the handshake cycle as a ready strobe with data.
// Ports:
//   clock, reset           - clock, asynchronous active-low reset
//   icache_r_valid_i/addr/len - refill request, held by the cache until last beat
//   icache_r_ready_o/data/last/err - per-beat strobe, data, final-beat flag, burst error
//   axi (master modport)   - AR and R channels
module ysyx_23060077_icache_axi_rd #(
    parameter int unsigned         ID_WIDTH = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID   = '0,
    parameter logic [7:0]          MAX_LEN  = 8'd15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        icache_r_valid_i,
    input  logic [31:0] icache_r_addr_i,
    input  logic [7:0]  icache_r_len_i,
    output logic        icache_r_ready_o,
    output logic [31:0] icache_r_data_o,
    output logic        icache_r_last_o,
    output logic        icache_r_err_o,
    ysyx_23060077_icache_axi_rd_if.master axi
);

    localparam int unsigned CNT_W = 9;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]       state_q,    state_d;
    logic             arvalid_q,  arvalid_d;
    logic             rready_q,   rready_d;
    logic [31:0]      araddr_q,   araddr_d;
    logic [7:0]       arlen_q,    arlen_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             err_acc_q,  err_acc_d;
    logic             fwd_en_q,   fwd_en_d;

    // Per-beat qualifiers for the current R beat
    logic beat_c;
    logic in_range_c;
    logic beat_bad_c;
    logic fwd_c;

    assign beat_c     = (state_q == S_DATA) && axi.rvalid;
    assign in_range_c = beat_cnt_q <= CNT_W'(arlen_q);
    // Wrong ID, non-OKAY response, rlast at the wrong beat, or a beat past arlen
    assign beat_bad_c = (axi.rresp != 2'b00) || (axi.rid != AXI_ID) || !in_range_c ||
                        (axi.rlast && (beat_cnt_q != CNT_W'(arlen_q)));
    // A request withdrawn by the cache stops forwarding immediately, including this cycle
    assign fwd_c      = fwd_en_q && icache_r_valid_i;

    assign icache_r_ready_o = beat_c && fwd_c && in_range_c;
    assign icache_r_data_o  = (state_q == S_DATA) ? axi.rdata : 32'd0;
    assign icache_r_last_o  = icache_r_ready_o && axi.rlast;
    // Error from earlier beats or from the final beat itself
    assign icache_r_err_o   = icache_r_last_o && (err_acc_q || beat_bad_c);

    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = arlen_q;
    assign axi.arid    = AXI_ID;
    assign axi.arsize  = 3'b010;
    assign axi.arburst = 2'b01;
    assign axi.rready  = rready_q;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            araddr_q   <= 32'd0;
            arlen_q    <= 8'd0;
            beat_cnt_q <= '0;
            err_acc_q  <= 1'b0;
            fwd_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            beat_cnt_q <= beat_cnt_d;
            err_acc_q  <= err_acc_d;
            fwd_en_q   <= fwd_en_d;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_d    = state_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        beat_cnt_d = beat_cnt_q;
        err_acc_d  = err_acc_q;
        fwd_en_d   = fwd_en_q;

        case (state_q)
            S_IDLE: begin
                if (icache_r_valid_i) begin
                    state_d    = S_ADDR;
                    arvalid_d  = 1'b1;
                    araddr_d   = icache_r_addr_i & 32'hFFFF_FFFC;
                    // Oversized requests are clamped and flagged up front
                    arlen_d    = (icache_r_len_i > MAX_LEN) ? MAX_LEN : icache_r_len_i;
                    err_acc_d  = icache_r_len_i > MAX_LEN;
                    beat_cnt_d = '0;
                    fwd_en_d   = 1'b1;
                end
            end
            S_ADDR: begin
                if (!icache_r_valid_i) begin
                    fwd_en_d = 1'b0;
                end
                if (arvalid_q && axi.arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (!icache_r_valid_i) begin
                    fwd_en_d = 1'b0;
                end
                if (axi.rvalid) begin
                    if (axi.rlast) begin
                        // rlast ends the burst regardless of the beat count
                        state_d    = S_IDLE;
                        rready_d   = 1'b0;
                        beat_cnt_d = '0;
                        err_acc_d  = 1'b0;
                        fwd_en_d   = 1'b0;
                    end else begin
                        beat_cnt_d = (beat_cnt_q == '1) ? beat_cnt_q
                                                        : CNT_W'(beat_cnt_q + CNT_W'(1));
                        err_acc_d  = err_acc_q || beat_bad_c;
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060077_icache_axi_rd.sv
// Self-checking bench: the bench plays both the icache and the AXI slave, and
// predicts every cache-side strobe from the request/beat rules per burst.
module tb_ysyx_23060077_icache_axi_rd;

    localparam int unsigned ID_WIDTH = 4;
    localparam int unsigned MAX_LEN  = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        icache_r_valid_i = 1'b0;
    logic [31:0] icache_r_addr_i  = 32'd0;
    logic [7:0]  icache_r_len_i   = 8'd0;
    logic        icache_r_ready_o;
    logic [31:0] icache_r_data_o;
    logic        icache_r_last_o;
    logic        icache_r_err_o;

    ysyx_23060077_icache_axi_rd_if #(.ID_WIDTH(ID_WIDTH)) axi ();

    ysyx_23060077_icache_axi_rd #(
        .ID_WIDTH(ID_WIDTH),
        .AXI_ID  (4'd0),
        .MAX_LEN (8'd15)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .icache_r_valid_i(icache_r_valid_i),
        .icache_r_addr_i (icache_r_addr_i),
        .icache_r_len_i  (icache_r_len_i),
        .icache_r_ready_o(icache_r_ready_o),
        .icache_r_data_o (icache_r_data_o),
        .icache_r_last_o (icache_r_last_o),
        .icache_r_err_o  (icache_r_err_o),
        .axi             (axi)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int ar_hs = 0;

    always @(posedge clock) begin
        if (reset && axi.arvalid && axi.arready) ar_hs <= ar_hs + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One refill request against a scripted slave; expectations come from the burst rules.
    task automatic run_txn(input logic [31:0] addr, input logic [7:0] len, input int ar_delay,
                           input int nbeats, input int gap_fixed, input int gap_max,
                           input int bad_resp_beat, input int bad_id_beat, input int cancel_beat,
                           input logic [31:0] data_base, input bit keep_valid, input bit b2b);
        int  exp_len;
        bit  err_seen;
        bit  fwd_ok;
        bit  bad;
        bit  fwd;
        bit  e_last;
        bit  e_err;
        int  pulses;
        int  exp_pulses;
        int  hs0;
        int  gaps;
        exp_len    = (int'(len) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(len);
        err_seen   = int'(len) > int'(MAX_LEN);
        fwd_ok     = 1'b1;
        pulses     = 0;
        exp_pulses = 0;
        hs0        = ar_hs;

        if (!b2b) step();
        icache_r_valid_i = 1'b1;
        icache_r_addr_i  = addr;
        icache_r_len_i   = len;
        if (!b2b) begin
            @(negedge clock);
            check("arvalid_early", 32'(axi.arvalid), 32'd0);
        end

        for (int d = 0; d <= ar_delay; d++) begin
            step();
            axi.arready = (d == ar_delay);
            @(negedge clock);
            check("arvalid_hold", 32'(axi.arvalid), 32'd1);
            check("araddr", axi.araddr, {addr[31:2], 2'b00});
            check("arlen", 32'(axi.arlen), 32'(exp_len));
            if (d == 0) begin
                check("arid", 32'(axi.arid), 32'd0);
                check("arsize", 32'(axi.arsize), 32'd2);
                check("arburst", 32'(axi.arburst), 32'd1);
            end
        end

        for (int b = 0; b < nbeats; b++) begin
            step();
            axi.arready = 1'b0;
            gaps = gap_fixed + ((gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
            for (int g = 0; g < gaps; g++) begin
                axi.rvalid = 1'b0;
                axi.rlast  = 1'b0;
                @(negedge clock);
                check("rready_gap", 32'(axi.rready), 32'd1);
                check("ready_gap", 32'(icache_r_ready_o), 32'd0);
                step();
            end
            if (b == cancel_beat) icache_r_valid_i = 1'b0;
            if (b >= cancel_beat && cancel_beat >= 0) fwd_ok = 1'b0;
            axi.rvalid = 1'b1;
            axi.rdata  = data_base + 32'(b);
            axi.rresp  = (b == bad_resp_beat) ? 2'b10 : 2'b00;
            axi.rid    = (b == bad_id_beat) ? 4'h5 : 4'h0;
            axi.rlast  = (b == nbeats - 1);

            bad    = (axi.rresp != 2'b00) || (axi.rid != 4'h0) || (b > exp_len) ||
                     (axi.rlast && (b != exp_len));
            fwd    = fwd_ok && (b <= exp_len);
            e_last = fwd && axi.rlast;
            e_err  = e_last && (err_seen || bad);
            err_seen = err_seen || bad;
            if (fwd) exp_pulses++;

            @(negedge clock);
            if (icache_r_ready_o) pulses++;
            check("rready_beat", 32'(axi.rready), 32'd1);
            check("arvalid_data", 32'(axi.arvalid), 32'd0);
            check("ready_beat", 32'(icache_r_ready_o), 32'(fwd));
            if (fwd) check("data_beat", icache_r_data_o, data_base + 32'(b));
            check("last_beat", 32'(icache_r_last_o), 32'(e_last));
            check("err_beat", 32'(icache_r_err_o), 32'(e_err));
        end

        step();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
        axi.rid    = 4'h0;
        if (!keep_valid) icache_r_valid_i = 1'b0;
        @(negedge clock);
        check("rready_idle", 32'(axi.rready), 32'd0);
        check("ready_idle", 32'(icache_r_ready_o), 32'd0);
        check("arvalid_idle", 32'(axi.arvalid), 32'd0);
        check("ar_count", 32'(ar_hs - hs0), 32'd1);
        check("pulse_count", 32'(pulses), 32'(exp_pulses));
    endtask

    // Reset asserted in the middle of the second beat
    task automatic reset_mid_burst();
        step();
        icache_r_valid_i = 1'b1;
        icache_r_addr_i  = 32'h8000_0040;
        icache_r_len_i   = 8'd3;
        step();
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        axi.rvalid  = 1'b1;
        axi.rdata   = 32'h1111_0000;
        axi.rlast   = 1'b0;
        @(negedge clock);
        check("rst_beat0", 32'(icache_r_ready_o), 32'd1);
        step();
        axi.rdata = 32'h1111_0001;
        #2;
        reset = 1'b0;
        #1;
        check("rst_ready", 32'(icache_r_ready_o), 32'd0);
        check("rst_data", icache_r_data_o, 32'd0);
        check("rst_last", 32'(icache_r_last_o), 32'd0);
        check("rst_err", 32'(icache_r_err_o), 32'd0);
        check("rst_arvalid", 32'(axi.arvalid), 32'd0);
        check("rst_rready", 32'(axi.rready), 32'd0);
        check("rst_araddr", axi.araddr, 32'd0);
        check("rst_arlen", 32'(axi.arlen), 32'd0);
        step();
        axi.rvalid = 1'b0;
        icache_r_valid_i = 1'b0;
        step();
        reset = 1'b1;
    endtask

    initial begin
        int  len;
        int  nb;
        int  el;
        bit  keep;
        bit  prev_keep;
        axi.arready = 1'b0;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'd0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b0;
        axi.rid     = 4'h0;

        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_arvalid", 32'(axi.arvalid), 32'd0);
        check("reset_rready", 32'(axi.rready), 32'd0);
        check("reset_araddr", axi.araddr, 32'd0);
        check("reset_arlen", 32'(axi.arlen), 32'd0);
        check("reset_ready", 32'(icache_r_ready_o), 32'd0);
        check("reset_last", 32'(icache_r_last_o), 32'd0);
        check("reset_err", 32'(icache_r_err_o), 32'd0);
        step();
        reset = 1'b1;

        // addr, len, ar_delay, nbeats, gap_fixed, gap_max, bad_resp, bad_id, cancel, data, keep, b2b
        run_txn(32'h8000_0010, 8'd3, 0, 4, 0, 0, -1, -1, -1, 32'hA, 1'b0, 1'b0);
        run_txn(32'h8000_0020, 8'd3, 5, 4, 0, 0, -1, -1, -1, 32'h100, 1'b0, 1'b0);
        run_txn(32'h8000_0030, 8'd3, 1, 4, 2, 0, -1, -1, -1, 32'h200, 1'b0, 1'b0);
        run_txn(32'h8000_0040, 8'd3, 0, 4, 0, 0, 2, -1, -1, 32'h300, 1'b0, 1'b0);
        run_txn(32'h8000_0050, 8'd3, 0, 4, 0, 1, -1, -1, 1, 32'h400, 1'b0, 1'b0);
        reset_mid_burst();
        run_txn(32'h8000_0060, 8'd3, 0, 4, 0, 0, -1, -1, -1, 32'h500, 1'b0, 1'b0);
        // Oversized request clamps to MAX_LEN and reports an error at last
        run_txn(32'h8000_1000, 8'd20, 0, 16, 0, 0, -1, -1, -1, 32'h600, 1'b0, 1'b0);
        // Early rlast, extra beats beyond arlen, wrong ID
        run_txn(32'h8000_2000, 8'd3, 0, 2, 0, 0, -1, -1, -1, 32'h700, 1'b0, 1'b0);
        run_txn(32'h8000_3000, 8'd3, 0, 6, 0, 0, -1, -1, -1, 32'h800, 1'b0, 1'b0);
        run_txn(32'h8000_4000, 8'd3, 0, 4, 0, 0, -1, 1, -1, 32'h900, 1'b0, 1'b0);
        // Single-beat burst and unaligned address
        run_txn(32'h8000_5007, 8'd0, 2, 1, 0, 0, -1, -1, -1, 32'hA00, 1'b0, 1'b0);
        // Back-to-back requests with valid held across the IDLE cycle
        run_txn(32'h8000_6000, 8'd3, 0, 4, 0, 0, -1, -1, -1, 32'hB00, 1'b1, 1'b0);
        run_txn(32'h8000_6010, 8'd3, 1, 4, 0, 0, -1, -1, -1, 32'hC00, 1'b0, 1'b1);

        prev_keep = 1'b0;
        for (int t = 0; t < 40; t++) begin
            len = ($urandom_range(3, 0) == 0) ? int'($urandom_range(20, 0)) : 3;
            el  = (len > int'(MAX_LEN)) ? int'(MAX_LEN) : len;
            nb  = el + 1;
            if ($urandom_range(5, 0) == 0) nb = int'($urandom_range(el + 3, 1));
            keep = ($urandom_range(3, 0) == 0);
            run_txn({$urandom_range(32'hFFFF, 0), 16'h0} | 32'($urandom_range(255, 0)),
                    8'(len), int'($urandom_range(3, 0)), nb, 0, int'($urandom_range(2, 0)),
                    ($urandom_range(4, 0) == 0) ? int'($urandom_range(nb - 1, 0)) : -1,
                    ($urandom_range(6, 0) == 0) ? int'($urandom_range(nb - 1, 0)) : -1,
                    ($urandom_range(5, 0) == 0) ? int'($urandom_range(nb, 0)) : -1,
                    $urandom, keep, prev_keep);
            prev_keep = keep;
        end
        if (prev_keep) begin
            step();
            icache_r_valid_i = 1'b0;
            repeat (30) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
